// File: rtl/seg7_bcd_scan.sv
// N-digit multiplexed seven-segment display with a sequential double-dabble binary-to-BCD converter.
// Optional blink gating is built only when BLINK_EN is defined.
module seg7_bcd_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned VAL_W       = 14,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                  clk_50MHz,
    input  logic                  rst_n,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    output logic                  busy,
    output logic                  ovf,
    input  logic                  blink,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            a_to_g
);

    localparam int unsigned DIV_RAW    = CLK_HZ / SCAN_HZ;
    localparam int unsigned DIV        = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCD_DIGITS = (VAL_W * 30103 + 99999) / 100000 + 1;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned PAD_DIGITS = ((BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS) + 1;
    localparam int unsigned PAD_W      = 4 * PAD_DIGITS;
    localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W      = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [VAL_W-1:0]        r_shift;
    logic [BCD_W-1:0]        r_bcd;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [PAD_W-1:0]        w_pad;
    logic [CNT_W-1:0]        r_cnt;
    logic [DISP_W-1:0]       r_disp;
    logic [PRE_W-1:0]        r_pre;
    logic                    w_tick;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_lz_run;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_mute;
    logic [6:0]              w_seg;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b0000001;
            4'd1:    f_seg = 7'b1001111;
            4'd2:    f_seg = 7'b0010010;
            4'd3:    f_seg = 7'b0000110;
            4'd4:    f_seg = 7'b1001100;
            4'd5:    f_seg = 7'b0100100;
            4'd6:    f_seg = 7'b0100000;
            4'd7:    f_seg = 7'b0001111;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0000100;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (load) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_cnt == CNT_W'(VAL_W - 1)) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Upper padding digits are nonzero exactly when the value exceeds the display range
    assign w_pad = PAD_W'(r_bcd);

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: if (load) begin
                    r_shift <= value;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                end
                S_SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + CNT_W'(1);
                end
                S_COMMIT: begin
                    r_disp <= w_pad[DISP_W-1:0];
                    ovf    <= |w_pad[PAD_W-1:DISP_W];
                end
                default: ;
            endcase
        end
    end

    assign w_tick = (r_pre == PRE_W'(DIV - 1));

    // Scan prescaler
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n)      r_pre <= '0;
        else if (w_tick) r_pre <= '0;
        else             r_pre <= r_pre + PRE_W'(1);
    end

`ifdef BLINK_EN
    localparam int unsigned BT_W = $clog2(BLINK_TICKS + 1);
    logic [BT_W-1:0] r_bcnt;
    logic            r_phase;

    // Blink phase toggles every BLINK_TICKS scan ticks while blink is requested
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (!blink) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_bcnt == BT_W'(BLINK_TICKS - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + BT_W'(1);
            end
        end
    end

    assign w_mute = blink & r_phase;
`else
    logic [1:0] w_unused_blink;
    assign w_unused_blink = {blink, BLINK_TICKS == 0};
    assign w_mute         = 1'b0;
`endif

    // Digit select, leading-zero blanking and segment decode
    always_comb begin
        w_nib    = 4'd0;
        w_blank  = 1'b0;
        w_lz_run = 1'b1;
        w_lz     = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            w_lz_run = w_lz_run & (r_disp[4*i +: 4] == 4'd0);
            w_lz[i]  = w_lz_run;
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_blank = (i != 0) && w_lz[i];
            end
        end
        w_an = ~(NUM_DIGITS'(1) << r_idx);
        if (w_mute || (w_blank && !ovf)) w_seg = 7'b1111111;
        else if (ovf)                    w_seg = 7'b1111110;
        else                             w_seg = f_seg(w_nib);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            an     <= '1;
            a_to_g <= 7'b1111111;
        end else if (w_tick) begin
            an     <= w_an;
            a_to_g <= w_seg;
            r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed self-checking bench for seg7_bcd_scan (4 digits, 14-bit value, scan tick every 4 clocks).
module tb_seg7_bcd_scan;

    localparam logic [6:0] SEG_0  = 7'b0000001;
    localparam logic [6:0] SEG_1  = 7'b1001111;
    localparam logic [6:0] SEG_3  = 7'b0000110;
    localparam logic [6:0] SEG_5  = 7'b0100100;
    localparam logic [6:0] SEG_9  = 7'b0000100;
    localparam logic [6:0] SEG_BL = 7'b1111111;
    localparam logic [6:0] SEG_DS = 7'b1111110;

    logic        clk_50MHz = 1'b0;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic        blink;
    logic [3:0]  an;
    logic [6:0]  a_to_g;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_bcd_scan #(
        .NUM_DIGITS (4),
        .VAL_W      (14),
        .CLK_HZ     (1000),
        .SCAN_HZ    (250),
        .BLINK_TICKS(2)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .ovf      (ovf),
        .blink    (blink),
        .an       (an),
        .a_to_g   (a_to_g)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag);
        logic [3:0] prev;
        int n;
        prev = an;
        n = 0;
        do begin
            @(negedge clk_50MHz);
            n++;
        end while (an === prev && n < 8);
        chk({tag, "_tick"}, 32'(an !== prev), 32'd1);
    endtask

    task automatic expect_digits(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0);
        logic [27:0] exp;
        logic [3:0]  want;
        int n;
        exp = {s3, s2, s1, s0};
        wait_tick(tag);
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            while (an !== want && n < 12) begin
                @(negedge clk_50MHz);
                n++;
            end
            chk($sformatf("%s_an%0d", tag, d), 32'(an), 32'(want));
            chk($sformatf("%s_seg%0d", tag, d), 32'(a_to_g), 32'(exp[7*d +: 7]));
        end
    endtask

    task automatic convert(input string tag, input logic [13:0] v, input bit interfere);
        int len;
        @(negedge clk_50MHz);
        value = v;
        load  = 1'b1;
        @(negedge clk_50MHz);
        load = 1'b0;
        len  = 0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            if (interfere && len == 3) begin
                value = 14'd42;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk_50MHz);
        end
        load = 1'b0;
        chk({tag, "_busy_len"}, 32'(len), 32'd15);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        blink = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(a_to_g), 32'(SEG_BL));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // First tick lands on the fourth edge after release
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        chk("pre_tick_an", 32'(an), 32'hF);
        chk("pre_tick_seg", 32'(a_to_g), 32'(SEG_BL));
        @(negedge clk_50MHz);
        chk("tick0_an", 32'(an), 32'hE);
        chk("tick0_seg", 32'(a_to_g), 32'(SEG_0));
        chk("tick0_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk_50MHz);
        chk("rot1_an", 32'(an), 32'hD);
        chk("rot1_seg", 32'(a_to_g), 32'(SEG_BL));
        repeat (4) @(negedge clk_50MHz);
        chk("rot2_an", 32'(an), 32'hB);
        repeat (4) @(negedge clk_50MHz);
        chk("rot3_an", 32'(an), 32'h7);
        repeat (4) @(negedge clk_50MHz);
        chk("rot4_an", 32'(an), 32'hE);

        convert("v13", 14'd13, 1'b0);
        chk("v13_ovf", 32'(ovf), 32'd0);
        expect_digits("v13", SEG_BL, SEG_BL, SEG_1, SEG_3);

        convert("v9999", 14'd9999, 1'b0);
        chk("v9999_ovf", 32'(ovf), 32'd0);
        expect_digits("v9999", SEG_9, SEG_9, SEG_9, SEG_9);

        convert("v10000", 14'd10000, 1'b0);
        chk("v10000_ovf", 32'(ovf), 32'd1);
        expect_digits("v10000", SEG_DS, SEG_DS, SEG_DS, SEG_DS);

        // A load of 42 during this conversion must be dropped
        convert("v305", 14'd305, 1'b1);
        chk("v305_ovf", 32'(ovf), 32'd0);
        chk("v305_busy_after", 32'(busy), 32'd0);
        expect_digits("v305", SEG_BL, SEG_3, SEG_0, SEG_5);

        @(negedge clk_50MHz);
        value = 14'd777;
        load  = 1'b1;
        @(negedge clk_50MHz);
        load = 1'b0;
        repeat (4) @(negedge clk_50MHz);
        chk("v777_busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("v777_rst_busy", 32'(busy), 32'd0);
        chk("v777_rst_an", 32'(an), 32'hF);
        chk("v777_rst_seg", 32'(a_to_g), 32'(SEG_BL));
        repeat (2) @(negedge clk_50MHz);
        rst_n = 1'b1;
        expect_digits("v777", SEG_BL, SEG_BL, SEG_BL, SEG_0);
        chk("v777_ovf", 32'(ovf), 32'd0);
        chk("v777_busy_after", 32'(busy), 32'd0);

        convert("blk9999", 14'd9999, 1'b0);
        expect_digits("blk_pre", SEG_9, SEG_9, SEG_9, SEG_9);
        @(negedge clk_50MHz);
        blink = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick($sformatf("blk%0d", k));
`ifdef BLINK_EN
            chk($sformatf("blk%0d_seg", k), 32'(a_to_g), 32'(((k / 2) % 2 == 0) ? SEG_9 : SEG_BL));
`else
            chk($sformatf("blk%0d_seg", k), 32'(a_to_g), 32'(SEG_9));
`endif
        end
        blink = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_tick($sformatf("unblk%0d", k));
            chk($sformatf("unblk%0d_seg", k), 32'(a_to_g), 32'(SEG_9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
